// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the BCD 7-segment display converter:
// FSM state encoding, segment patterns and a decimal power helper.
package bcd_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Entry d holds the pattern for decimal digit d.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational single-digit encoder: BCD nibble to 7 segments.
// Dash has priority over blank; non-decimal nibbles render blank.
module seg7_digit_enc
  import bcd_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (!i_blank && (i_bcd <= 4'd9)) begin
      o_seg = SEG_DIGIT[i_bcd];
    end
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Binary to multi-digit 7-segment converter using sequential double-dabble.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for load; seg_out holds the last result
// ST_SHIFT | one add-3 / shift step per cycle, BIN_W cycles in total
// ST_LATCH | encode accumulator into seg_out, pulse done, return to idle
module bcd_seg_display
  import bcd_seg_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int          BCD_W  = 4 * (DIGITS + 1);
  localparam int          CNT_W  = $clog2(BIN_W + 1);
  localparam int unsigned OVF_TH = pow10(DIGITS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIN_W-1:0]      r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [BCD_W-2:0]      w_bcd_adj;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_pend;
  logic                  r_ovf;
  logic                  r_busy;
  logic                  r_done;
  logic [7*DIGITS-1:0]   r_seg;
  logic [7*DIGITS-1:0]   w_seg;
  logic [DIGITS-1:0]     w_blank;
  logic                  w_accept;
  logic                  w_shift;
  logic                  w_latch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        w_latch     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The top bit of the adjusted accumulator is shifted out, so only its low 3 bits are kept.
  always_comb begin
    logic [3:0] v_nib;
    w_bcd_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      v_nib = r_bcd[4*k +: 4];
      if (v_nib >= 4'd5) v_nib = v_nib + 4'd3;
      w_bcd_adj[4*k +: 4] = v_nib;
    end
    v_nib = r_bcd[4*DIGITS +: 4];
    if (v_nib >= 4'd5) v_nib = v_nib + 4'd3;
    w_bcd_adj[4*DIGITS +: 3] = v_nib[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_seg      <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_latch;
      if (w_accept) begin
        r_bin      <= bin_in;
        r_bcd      <= '0;
        r_cnt      <= CNT_W'(BIN_W);
        r_ovf_pend <= (32'(bin_in) >= OVF_TH);
      end else if (w_shift) begin
        r_bcd <= {w_bcd_adj, r_bin[BIN_W-1]};
        r_bin <= {r_bin[BIN_W-2:0], 1'b0};
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_latch) begin
        r_seg <= w_seg;
        r_ovf <= r_ovf_pend;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit blanks while everything above it and itself is zero.
  always_comb begin
    logic v_zero_above;
    w_blank      = '0;
    v_zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      v_zero_above = v_zero_above && (r_bcd[4*k +: 4] == 4'd0);
      w_blank[k]   = v_zero_above;
    end
  end
`else
  assign w_blank = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg7_digit_enc u_enc (
      .i_bcd   (r_bcd[4*k +: 4]),
      .i_blank (w_blank[k]),
      .i_dash  (r_ovf_pend),
      .o_seg   (w_seg[7*k +: 7])
    );
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign seg_out  = r_seg;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: a 3-digit and a 2-digit instance share
// stimulus and are compared against an arithmetic model of the displayed digits.
module tb_bcd_seg_display;

  localparam int BIN_W = 8;
  localparam int D_A   = 3;
  localparam int D_B   = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;

  logic             busy_a, done_a, ovf_a;
  logic [7*D_A-1:0] seg_a;
  logic             busy_b, done_b, ovf_b;
  logic [7*D_B-1:0] seg_b;

  int n_chk  = 0;
  int n_pass = 0;

  logic [41:0] exp_seg_a = '0;
  logic [41:0] exp_seg_b = '0;
  logic        exp_ovf_a = 1'b0;
  logic        exp_ovf_b = 1'b0;

  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  bcd_seg_display #(.BIN_W(BIN_W), .DIGITS(D_A)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .load     (load),
    .busy     (busy_a),
    .done     (done_a),
    .overflow (ovf_a),
    .seg_out  (seg_a)
  );

  bcd_seg_display #(.BIN_W(BIN_W), .DIGITS(D_B)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .load     (load),
    .busy     (busy_b),
    .done     (done_b),
    .overflow (ovf_b),
    .seg_out  (seg_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int lim_of(input int nd);
    int l;
    l = 1;
    for (int i = 0; i < nd; i++) l = l * 10;
    return l;
  endfunction

  function automatic logic [41:0] model_seg(input int val, input int nd);
    logic [41:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (val >= lim_of(nd))            r[7*k +: 7] = 7'h40;
      else if (LZB && k > 0 && val < p) r[7*k +: 7] = 7'h00;
      else                              r[7*k +: 7] = 7'(seg_tab[(val / p) % 10]);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_busy_b"}, busy_b, 0);
    chk({tag, "_done_a"}, done_a, 0);
    chk({tag, "_done_b"}, done_b, 0);
    chk({tag, "_ovf_a"}, ovf_a, exp_ovf_a);
    chk({tag, "_ovf_b"}, ovf_b, exp_ovf_b);
    chk({tag, "_seg_a"}, seg_a, exp_seg_a[7*D_A-1:0]);
    chk({tag, "_seg_b"}, seg_b, exp_seg_b[7*D_B-1:0]);
  endtask

  // Starts at #1 after an edge with the DUT idle. xedge selects the edge at which a
  // second load is presented (values outside 1..BIN_W+1 mean none).
  task automatic run_conv(input int val, input int xedge, input int xval);
    bin_in = BIN_W'(val);
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    for (int k = 1; k <= BIN_W + 1; k++) begin
      if (k == xedge) begin
        bin_in = BIN_W'(xval);
        load   = 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0;
      if (k <= BIN_W) begin
        chk("busy_mid_a", busy_a, 1);
        chk("busy_mid_b", busy_b, 1);
        chk("done_mid", {done_a, done_b}, 0);
        chk("hold_seg_a", seg_a, exp_seg_a[7*D_A-1:0]);
        chk("hold_seg_b", seg_b, exp_seg_b[7*D_B-1:0]);
      end
    end
    exp_seg_a = model_seg(val, D_A);
    exp_seg_b = model_seg(val, D_B);
    exp_ovf_a = (val >= lim_of(D_A));
    exp_ovf_b = (val >= lim_of(D_B));
    chk("done_a", done_a, 1);
    chk("done_b", done_b, 1);
    chk("busy_end_a", busy_a, 0);
    chk("seg_a", seg_a, exp_seg_a[7*D_A-1:0]);
    chk("seg_b", seg_b, exp_seg_b[7*D_B-1:0]);
    chk("ovf_a", ovf_a, exp_ovf_a);
    chk("ovf_b", ovf_b, exp_ovf_b);
    @(posedge clk); #1;
    chk_idle("after");
  endtask

  initial begin
    int v, xe, xv;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("in_reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset_idle");

    run_conv(237, 0, 0);
    run_conv(5, 0, 0);
    run_conv(0, 0, 0);
    run_conv(255, 0, 0);
    run_conv(100, 0, 0);
    run_conv(99, 0, 0);
    run_conv(200, 3, 17);
    run_conv(10, BIN_W + 1, 77);

    // Reset asserted at edge 4 of a conversion.
    bin_in = BIN_W'(123);
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    exp_seg_a = '0;
    exp_seg_b = '0;
    exp_ovf_a = 1'b0;
    exp_ovf_b = 1'b0;
    chk_idle("abort_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < BIN_W + 2; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {done_a, done_b, busy_a, busy_b}, 0);
    end
    run_conv(42, 0, 0);

    for (int i = 0; i < 40; i++) begin
      v  = int'($urandom_range(0, 255));
      xe = int'($urandom_range(0, BIN_W + 3));
      xv = int'($urandom_range(0, 255));
      run_conv(v, xe, xv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display.md
BCD_SEG_DISPLAY -- requirements
Module: bcd_seg_display

Interface
REQ-001 SHALL have parameter BIN_W, default 8, meaning binary input width (2..20).
REQ-002 SHALL have parameter DIGITS, default 3, meaning number of decimal digits driven (1..6).
REQ-003 SHALL have port clk, input, 1, the single clock (all logic on rising edge).
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port bin_in, input, BIN_W, unsigned value to display.
REQ-006 SHALL have port load, input, 1, request to convert bin_in (sampled on a rising edge).
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when new digits are on seg_out.
REQ-009 SHALL have port overflow, output, 1, high when the last converted value is >= 10^DIGITS.
REQ-010 SHALL have port seg_out, output, 7*DIGITS, active-high segments {g,f,e,d,c,b,a}; digit k (k=0 is least significant) occupies bits [7k+6:7k].

Function
REQ-011 SHALL implement FSM IDLE -> SHIFT -> LATCH -> IDLE.
REQ-012 In IDLE, load=1 SHALL capture bin_in, clear the BCD accumulator, set the shift count to BIN_W, and go to SHIFT; busy SHALL rise on the next cycle.
REQ-013 In SHIFT, each cycle SHALL add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by one and decrement the count; after BIN_W shift cycles the FSM SHALL go to LATCH.
REQ-014 In LATCH, seg_out and overflow SHALL update, done SHALL pulse for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-015 Latency: load sampled at edge 0 SHALL give seg_out updated and done=1 after edge BIN_W+1; busy SHALL be high from edge 1 through edge BIN_W+1 inclusive.
REQ-016 load while busy SHALL be ignored, with no queuing; load in the LATCH cycle SHALL be ignored.
REQ-017 seg_out SHALL hold the previous result for the whole conversion (no flicker).
REQ-018 The BCD accumulator SHALL be 4*(DIGITS+1) bits wide; overflow SHALL be 1 if the captured value >= 10^DIGITS.
REQ-019 On overflow, every digit SHALL show dash 7'b1000000.
REQ-020 Digit encodings SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); blank SHALL be 00.

Reset
REQ-021 rst=1 SHALL force, asynchronously: FSM IDLE, busy=0, done=0, overflow=0, every seg_out digit blank (00), accumulator and counter cleared.
REQ-022 Reset mid-conversion SHALL abort it with no done pulse; the first load after reset release SHALL be accepted.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL blank every zero digit above the most significant non-zero digit; digit 0 SHALL always be shown, and dashes SHALL be unaffected.
REQ-024 Without LEADING_ZERO_BLANK_EN, all DIGITS digits SHALL display, including leading zeros.

Structure
REQ-025 Package bcd_seg_pkg SHALL hold the FSM state typedef, segment constants (SEG_BLANK, SEG_DASH, the digit table), and a constant function pow10(n) used for the overflow threshold.
REQ-026 A sub-module seg7_digit_enc (4-bit BCD plus blank and dash controls -> 7 segments, combinational) SHALL be instantiated DIGITS times.

Verification (BIN_W=8, DIGITS=3 unless stated)
REQ-027 Reset then idle -> seg_out=0x000000 equivalent (all 00), busy=0, done=0, overflow=0.
REQ-028 load with bin_in=237 -> done at edge 9; digits {2,3,7} = 5B,4F,07; overflow=0.
REQ-029 load with bin_in=5, with and without LEADING_ZERO_BLANK_EN -> {00,00,6D} vs {3F,3F,6D}; load with bin_in=0 and macro defined -> {00,00,3F}.
REQ-030 DIGITS=2, load with bin_in=100 -> overflow=1 and both digits 40; load with bin_in=99 -> overflow=0 and 6F,6F.
REQ-031 load 200, then load 17 at edge 3 -> second load ignored, exactly one done pulse showing 200; seg_out holds old value during busy.
REQ-032 Assert rst at edge 4 of a conversion -> no done pulse, outputs at reset values; the next load of 42 completes normally and shows 3F,66,5B.
